ccd_frame_capture: RTL and testbench

- Upstream stage of the RAM readout/imaging controller.
- On a `shoot` request it does three things:
  - generates the linear-CCD timing (phi, SH, ICG);
  - samples the 8-bit ADC once per pixel;
  - writes each pixel into the dual-port frame RAM write port.
- It publishes the current pixel index on `pxcount` and pulses `frameDone` when the last pixel is stored. The consumer then clears `shoot` and streams the RAM out.

---
 rtl/ccd_frame_capture.sv | 200 ++++++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// Linear-CCD frame capture: generates phi/SH/ICG timing, samples the ADC once per
// pixel and writes each pixel into the frame RAM write port, then pulses frameDone.
`timescale 1ns/1ps
module ccd_frame_capture #(
    parameter int NPIX       = 5475,
    parameter int PXDIV      = 8,
    parameter int SAMPLE_PH  = 5,
    parameter int ICG_LEAD   = 1,
    parameter int SH_PERIODS = 2,
    parameter int ICG_TAIL   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shoot,
    input  logic [7:0]  adc_data,
    output logic        ccd_phi,
    output logic        ccd_sh,
    output logic        ccd_icg,
    output logic [15:0] wraddress,
    output logic [7:0]  wrdata,
    output logic        wren,
    output logic [12:0] pxcount,
    output logic        frameDone
);

    localparam int DW = (PXDIV > 1) ? $clog2(PXDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(PXDIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(PXDIV / 2);
    localparam logic [DW-1:0] DIV_SAMP  = DW'(SAMPLE_PH);
    localparam logic [7:0]    LEAD_LAST = 8'(ICG_LEAD - 1);
    localparam logic [7:0]    SH_LAST   = 8'(SH_PERIODS - 1);
    localparam logic [7:0]    TAIL_LAST = 8'(ICG_TAIL - 1);
    localparam logic [12:0]   PIX_LAST  = 13'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SH    = 3'd2,
        TAIL  = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5,
        REARM = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic [DW-1:0] div_r, div_s;
    logic [7:0]    per_r, per_s;
    logic [12:0]   pix_r, pix_s;
    logic          phi_r, phi_s;
    logic          sh_r, sh_s;
    logic          icg_r, icg_s;
    logic          wren_r, wren_s;
    logic [15:0]   wraddr_r, wraddr_s;
    logic [7:0]    wrdata_r, wrdata_s;
    logic          done_r, done_s;
    logic          boundary_s;

    // Next-state and next-output computation for the divider and sequencer.
    always_comb begin
        boundary_s = (div_r == DIV_LAST);
        div_s      = boundary_s ? {DW{1'b0}} : div_r + DW'(1);
        // phi is computed from the next divider value so it tracks div in the same cycle
        phi_s      = (div_s < DIV_HALF);
        state_s    = state_r;
        per_s      = per_r;
        pix_s      = pix_r;
        sh_s       = sh_r;
        icg_s      = icg_r;
        wren_s     = 1'b0;
        wraddr_s   = wraddr_r;
        wrdata_s   = wrdata_r;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (boundary_s && shoot) begin
                    state_s = LEAD;
                    icg_s   = 1'b0;
                    per_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LEAD: begin
                if (boundary_s) begin
                    if (per_r == LEAD_LAST) begin
                        state_s = SH;
                        sh_s    = 1'b1;
                        per_s   = 8'd0;
                    end else begin
                        per_s = per_r + 8'd1;
                    end
                end else begin
                    state_s = LEAD;
                end
            end
            SH: begin
                if (boundary_s) begin
                    if (per_r == SH_LAST) begin
                        state_s = TAIL;
                        sh_s    = 1'b0;
                        per_s   = 8'd0;
                    end else begin
                        per_s = per_r + 8'd1;
                    end
                end else begin
                    state_s = SH;
                end
            end
            TAIL: begin
                if (boundary_s) begin
                    if (per_r == TAIL_LAST) begin
                        state_s = READ;
                        icg_s   = 1'b1;
                        pix_s   = 13'd0;
                    end else begin
                        per_s = per_r + 8'd1;
                    end
                end else begin
                    state_s = TAIL;
                end
            end
            READ: begin
                // wrdata doubles as the sample register; wren rises in the following cycle
                if (div_r == DIV_SAMP) begin
                    wren_s   = 1'b1;
                    wraddr_s = {3'b000, pix_r};
                    wrdata_s = adc_data;
                end else begin
                    wren_s = 1'b0;
                end
                if (boundary_s) begin
                    if (pix_r == PIX_LAST) begin
                        state_s = DONE;
                        pix_s   = 13'd0;
                        done_s  = 1'b1;
                    end else begin
                        pix_s = pix_r + 13'd1;
                    end
                end else begin
                    state_s = READ;
                end
            end
            DONE: begin
                state_s = REARM;
            end
            REARM: begin
                if (!shoot) begin
                    state_s = IDLE;
                end else begin
                    state_s = REARM;
                end
            end
            default: begin
                state_s = IDLE;
                sh_s    = 1'b0;
                icg_s   = 1'b1;
                pix_s   = 13'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            div_r    <= {DW{1'b0}};
            per_r    <= 8'd0;
            pix_r    <= 13'd0;
            phi_r    <= 1'b0;
            sh_r     <= 1'b0;
            icg_r    <= 1'b1;
            wren_r   <= 1'b0;
            wraddr_r <= 16'd0;
            wrdata_r <= 8'd0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            per_r    <= per_s;
            pix_r    <= pix_s;
            phi_r    <= phi_s;
            sh_r     <= sh_s;
            icg_r    <= icg_s;
            wren_r   <= wren_s;
            wraddr_r <= wraddr_s;
            wrdata_r <= wrdata_s;
            done_r   <= done_s;
        end
    end

    assign ccd_phi   = phi_r;
    assign ccd_sh    = sh_r;
    assign ccd_icg   = icg_r;
    assign wraddress = wraddr_r;
    assign wrdata    = wrdata_r;
    assign wren      = wren_r;
    assign pxcount   = pix_r;
    assign frameDone = done_r;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture: a 16-pixel instance for directed/random frames and
// a full-size instance for one complete 5475-pixel frame.
`timescale 1ns/1ps
module tb_ccd_frame_capture;

    localparam int NS  = 16;
    localparam int PXD = 8;
    localparam int NB  = 5475;
    localparam int PRE = 1 + 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // small instance
    logic        rst_n, shoot, phi, sh, icg, wren, done;
    logic [7:0]  adc, wd;
    logic [15:0] wa;
    logic [12:0] px;
    logic [7:0]  pat [0:NS-1];
    assign adc = pat[px[3:0]];

    ccd_frame_capture #(.NPIX(NS), .PXDIV(PXD), .SAMPLE_PH(5), .ICG_LEAD(1),
                        .SH_PERIODS(2), .ICG_TAIL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .shoot(shoot), .adc_data(adc),
        .ccd_phi(phi), .ccd_sh(sh), .ccd_icg(icg), .wraddress(wa),
        .wrdata(wd), .wren(wren), .pxcount(px), .frameDone(done));

    // full-size instance
    logic        rst_b_n, shoot_b, phi_b, sh_b, icg_b, wren_b, done_b;
    logic [7:0]  adc_b, wd_b, key_b;
    logic [15:0] wa_b;
    logic [12:0] px_b;
    assign adc_b = key_b ^ px_b[7:0];

    ccd_frame_capture dut_b (
        .clk(clk), .rst_n(rst_b_n), .shoot(shoot_b), .adc_data(adc_b),
        .ccd_phi(phi_b), .ccd_sh(sh_b), .ccd_icg(icg_b), .wraddress(wa_b),
        .wrdata(wd_b), .wren(wren_b), .pxcount(px_b), .frameDone(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // observations of the small instance
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [12:0] wp_q[$];
    logic prev_wren = 1'b0, prev_icg = 1'b1, prev_sh = 1'b0, prev_done = 1'b0, prev_phi = 1'b0;
    int wren_bad = 0, px_bad = 0, done_bad = 0, sh_out = 0;
    int icg_falls = 0, icg_fall_cyc = 0, icg_low_len = 0, sh_rise_cyc = 0, sh_len = 0;
    int done_cnt = 0, done_cyc = 0, done_wr = 0;
    int ph_seen = 0, ph_rise = 0, phi_bad = 0, phi_rises = 0;

    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wa_q.push_back(wa);
            wd_q.push_back(wd);
            wp_q.push_back(px);
        end
        if (wren === 1'b1 && prev_wren === 1'b1) wren_bad <= wren_bad + 1;
        if (px > 13'(NS - 1)) px_bad <= px_bad + 1;
        if (prev_icg === 1'b1 && icg === 1'b0) begin
            icg_falls    <= icg_falls + 1;
            icg_fall_cyc <= cyc;
        end
        if (prev_icg === 1'b0 && icg === 1'b1) icg_low_len <= cyc - icg_fall_cyc;
        if (prev_sh === 1'b0 && sh === 1'b1) sh_rise_cyc <= cyc;
        if (prev_sh === 1'b1 && sh === 1'b0) sh_len <= cyc - sh_rise_cyc;
        if (sh === 1'b1 && icg !== 1'b0) sh_out <= sh_out + 1;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_wr  <= wa_q.size();
        end
        if (done === 1'b1 && prev_done === 1'b1) done_bad <= done_bad + 1;
        if (rst_n !== 1'b1) begin
            ph_seen <= 0;
        end else begin
            if (prev_phi === 1'b0 && phi === 1'b1) begin
                if (ph_seen >= 2 && cyc - ph_rise != PXD) phi_bad <= phi_bad + 1;
                ph_rise   <= cyc;
                ph_seen   <= ph_seen + 1;
                phi_rises <= phi_rises + 1;
            end
            if (prev_phi === 1'b1 && phi === 1'b0) begin
                if (ph_seen >= 2 && cyc - ph_rise != PXD / 2) phi_bad <= phi_bad + 1;
            end
        end
        prev_wren <= wren;
        prev_icg  <= icg;
        prev_sh   <= sh;
        prev_done <= done;
        prev_phi  <= phi;
    end

    // observations of the full-size instance
    int exp_b = 0, bbad = 0, last_wa_b = -1, maxpx_b = 0;
    int icgfall_b_cyc = 0, done_b_cnt = 0, done_b_cyc = 0;
    logic prev_icg_b = 1'b1;
    always @(negedge clk) begin
        if (wren_b === 1'b1) begin
            if (wa_b !== 16'(exp_b) || wd_b !== (key_b ^ 8'(exp_b)) || px_b !== 13'(exp_b))
                bbad <= bbad + 1;
            exp_b     <= exp_b + 1;
            last_wa_b <= int'(wa_b);
        end
        if (rst_b_n === 1'b1 && int'(px_b) > maxpx_b) maxpx_b <= int'(px_b);
        if (prev_icg_b === 1'b1 && icg_b === 1'b0) icgfall_b_cyc <= cyc;
        if (done_b === 1'b1) begin
            done_b_cnt <= done_b_cnt + 1;
            done_b_cyc <= cyc;
        end
        prev_icg_b <= icg_b;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_px7(input int limit);
        int n = 0;
        while (px !== 13'd7 && n < limit) begin
            step();
            n++;
        end
        chk("px7_timeout", 32'(px === 13'd7), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(NS));
        for (int i = 0; i < NS && i < wa_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
            chk({tag, "_data"}, 32'(wd_q[i]), 32'(pat[i]));
            chk({tag, "_pxcount"}, 32'(wp_q[i]), 32'(i));
        end
        wa_q.delete();
        wd_q.delete();
        wp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phi"}, 32'(phi), 32'd0);
        chk({tag, "_sh"}, 32'(sh), 32'd0);
        chk({tag, "_icg"}, 32'(icg), 32'd1);
        chk({tag, "_wren"}, 32'(wren), 32'd0);
        chk({tag, "_wraddress"}, 32'(wa), 32'd0);
        chk({tag, "_wrdata"}, 32'(wd), 32'd0);
        chk({tag, "_pxcount"}, 32'(px), 32'd0);
        chk({tag, "_frameDone"}, 32'(done), 32'd0);
    endtask

    initial begin
        int rel_cyc, n_before, n;
        for (int i = 0; i < NS; i++) pat[i] = 8'(i * 3);
        key_b   = 8'($urandom_range(0, 255));
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        shoot   = 1'b1;
        shoot_b = 1'b0;

        // reset held with shoot high
        repeat (5) step();
        check_reset_outputs("reset");
        chk("reset_no_writes", 32'(wa_q.size()), 32'd0);

        // shoot already high at release: first frame, pattern i*3
        rst_n   = 1'b0;
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        rel_cyc = cyc;
        n = 0;
        while (icg_falls < 1 && n < 3 * PXD) begin
            step();
            n++;
        end
        chk("icg_fall_latency_ok", 32'((icg_falls == 1) && (icg_fall_cyc - rel_cyc <= PXD + 1)), 32'd1);
        wait_done(1, 400);
        chk("done_px_zero", 32'(px), 32'd0);
        chk("done_wr_count", 32'(done_wr), 32'(NS));
        chk("frame_len", 32'(done_cyc - icg_fall_cyc), 32'((PRE + NS) * PXD));
        chk("icg_low_len", 32'(icg_low_len), 32'(PRE * PXD));
        chk("sh_high_len", 32'(sh_len), 32'(2 * PXD));
        check_frame("basic");
        step();
        chk("done_one_cycle", 32'(done), 32'd0);

        // rearm: shoot still high, no new frame
        repeat (20) step();
        chk("rearm_no_refire", 32'(icg_falls), 32'd1);
        shoot = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NS; i++) pat[i] = 8'($urandom_range(0, 255));
        shoot = 1'b1;
        wait_done(2, 400);
        repeat (30) step();
        chk("rearm_one_frame", 32'(icg_falls), 32'd2);
        check_frame("rand");
        shoot = 1'b0;
        repeat (10) step();

        // shoot dropped mid-frame: frame completes
        shoot = 1'b1;
        wait_px7(400);
        shoot = 1'b0;
        wait_done(3, 400);
        check_frame("drop");
        repeat (40) step();
        chk("drop_no_refire", 32'(icg_falls), 32'd3);

        // reset mid-frame: writes stop, no frameDone
        shoot = 1'b1;
        wait_px7(400);
        n_before = wa_q.size();
        chk("midrst_writes_before", 32'(n_before), 32'd7);
        rst_n = 1'b0;
        step();
        check_reset_outputs("midrst");
        shoot = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (200) step();
        chk("midrst_no_done", 32'(done_cnt), 32'd3);
        chk("midrst_no_writes", 32'(wa_q.size()), 32'(n_before));

        chk("wren_single_cycle", 32'(wren_bad), 32'd0);
        chk("pxcount_bound", 32'(px_bad), 32'd0);
        chk("done_single_cycle", 32'(done_bad), 32'd0);
        chk("sh_inside_icg", 32'(sh_out), 32'd0);
        chk("phi_period_duty", 32'(phi_bad), 32'd0);
        chk("phi_running", 32'(phi_rises > 100), 32'd1);

        // full-size frame
        shoot_b = 1'b1;
        n = 0;
        while (done_b_cnt < 1 && n < 50000) begin
            step();
            n++;
        end
        chk("big_done_timeout", 32'(done_b_cnt), 32'd1);
        chk("big_px_after_done", 32'(px_b), 32'd0);
        shoot_b = 1'b0;
        chk("big_write_errors", 32'(bbad), 32'd0);
        chk("big_nwrites", 32'(exp_b), 32'(NB));
        chk("big_last_addr", 32'(last_wa_b), 32'(NB - 1));
        chk("big_max_pxcount", 32'(maxpx_b), 32'(NB - 1));
        chk("big_frame_len", 32'(done_b_cyc - icgfall_b_cyc), 32'((PRE + NB) * PXD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
